decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I instruction decode stage with valid/ready handshake, sitting between fetch and execute.
//  Splits each instruction into its fields, generates a sign-extended immediate for all six formats
//  (R/I/S/B/U/J) and flags illegal encodings.
//  Holds up to two decoded instructions in an output register plus a skid register, giving full throughput
//  under backpressure. Optional M-extension acceptance.
// PARAMETERS
//  XLEN      32  width of imm output; immediates are sign-extended to XLEN (legal values: 32, 64)
//  PC_WIDTH  32  width of pc_i/pc_o
//  M_EXT_EN  1   1: funct7=0000001 on OP (0110011) is legal; 0: flagged illegal
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         async reset, active high
//  flush_i   in   1         sync flush: discards held and incoming instructions
//  in_valid  in   1         inst_i/pc_i valid
//  in_ready  out  1         stage can accept this cycle
//  inst_i    in   32        instruction word
//  pc_i      in   PC_WIDTH  instruction address
//  out_valid out  1         decoded outputs valid
//  out_ready in   1         downstream accepts this cycle
//  opcode_o  out  7         inst[6:0]
//  rd_o      out  5         inst[11:7]; 0 for S/B formats
//  rs1_o     out  5         inst[19:15]; 0 for U/J formats
//  rs2_o     out  5         inst[24:20]; 0 unless R/S/B format
//  funct3_o  out  3         inst[14:12]
//  funct7_o  out  7         inst[31:25]
//  fmt_o     out  3         0=R 1=I 2=S 3=B 4=U 5=J 7=none
//  imm_o     out  XLEN      sign-extended immediate; 0 for R/none
//  illegal_o out  1         encoding not supported
//  pc_o      out  PC_WIDTH  pc of the decoded instruction
// BEHAVIOUR
//  - Reset (async): out_valid=0, skid empty, in_ready=1; all data outputs 0, fmt_o=7.
//  - Latency 1 cycle: an instruction accepted (in_valid&in_ready) at edge N appears at outputs after edge N.
//  - Transfer out on out_valid&out_ready. in_ready = !skid_valid (registered, no comb path from out_ready).
//  - Output reg empty or draining: an accepted instruction loads it. Output reg stalled: it goes to skid.
//  - On a drain while skid full, skid moves to output reg; ordering is strictly FIFO.
//  - out_valid held with stable data until accepted.
//  - flush_i (sync) clears out_valid and skid_valid; an in_valid in the same cycle is dropped.
//    in_ready=1 the next cycle.
//  - Format by opcode: 0110011 R; 0010011/0000011/1100111/1110011/0001111 I; 0100011 S; 1100011 B;
//    0110111/0010111 U; 1101111 J; else none + illegal.
//  - imm: I={inst[31:20]}; S={inst[31:25],inst[11:7]}; B={inst[31],inst[7],inst[30:25],inst[11:8],0};
//    U={inst[31:12],12'b0}; J={inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from inst[31].
//  - illegal_o also set for: inst[1:0]!=11; R with funct7 not 0000000/0100000
//    (0100000 only with funct3 000/101); funct7=0000001 when M_EXT_EN=0;
//    OP-IMM shift (funct3 001/101) with inst[31:25] not 0000000/0100000; B funct3 010/011.
//  - Illegal instructions are still passed downstream with illegal_o=1; no stall.
// TESTING
//  - ADD 002081b3 -> fmt=0 rd=3 rs1=1 rs2=2 funct3=0 funct7=0 imm=0 illegal=0, one cycle later.
//  - ADDI 05408113 -> fmt=1 rd=2 rs1=1 imm=0x00000054; LUI 000230B7 -> fmt=4 rd=1 imm=0x00023000.
//  - BNE fe111ce3 -> fmt=3 rs1=2 rs2=1 funct3=1 imm=0xFFFFFFF8; JAL ff9ff26f -> fmt=5 rd=4 imm=0xFFFFFFF8.
//  - Backpressure: stream 4 instrs, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted;
//    all 4 emerge in order, none lost or duplicated.
//  - MUL 022081b3: M_EXT_EN=1 -> illegal=0; M_EXT_EN=0 -> illegal=1. 0xFFFFFFFF -> fmt=7 illegal=1.
//  - flush_i with both entries full -> out_valid=0 next cycle; rst pulse mid-stream -> outputs at reset values.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, sign-extended immediates, illegal flagging; 1-cycle latency.
// Output register plus skid register; in_ready depends only on skid occupancy, never on out_ready.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32,
  parameter bit M_EXT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6:0]          opcode_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [2:0]          funct3_o,
  output logic [6:0]          funct7_o,
  output logic [2:0]          fmt_o,
  output logic [XLEN-1:0]     imm_o,
  output logic                illegal_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [2:0]          fmt;
    logic [XLEN-1:0]     imm;
    logic                illegal;
    logic [PC_WIDTH-1:0] pc;
  } dec_t;

  localparam dec_t DEC_RST = '{fmt: FMT_NONE, default: '0};

  dec_t        dec;
  dec_t        out_q;
  dec_t        skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic [31:0] imm32;
  logic        ill;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];

  always_comb begin
    dec        = '0;
    imm32      = '0;
    ill        = 1'b0;
    dec.opcode = inst_i[6:0];
    dec.rd     = inst_i[11:7];
    dec.rs1    = inst_i[19:15];
    dec.rs2    = inst_i[24:20];
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.pc     = pc_i;
    case (inst_i[6:0])
      7'b0110011: begin
        dec.fmt = FMT_R;
        case (f7)
          7'b0000000: ill = 1'b0;
          7'b0100000: ill = !(f3 == 3'b000 || f3 == 3'b101);
          7'b0000001: ill = !M_EXT_EN;
          default:    ill = 1'b1;
        endcase
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec.fmt = FMT_I;
        imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
        // Shift-immediates reuse the top bits as a funct7-like qualifier.
        if (inst_i[6:0] == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101) &&
            !(f7 == 7'b0000000 || f7 == 7'b0100000))
          ill = 1'b1;
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        ill     = (f3 == 3'b010 || f3 == 3'b011);
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {inst_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: begin
        dec.fmt = FMT_NONE;
        ill     = 1'b1;
      end
    endcase
    if (inst_i[1:0] != 2'b11) ill = 1'b1;
    if (dec.fmt == FMT_S || dec.fmt == FMT_B) dec.rd = '0;
    if (dec.fmt == FMT_U || dec.fmt == FMT_J) dec.rs1 = '0;
    if (!(dec.fmt == FMT_R || dec.fmt == FMT_S || dec.fmt == FMT_B)) dec.rs2 = '0;
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = ill;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= DEC_RST;
      skid_q       <= DEC_RST;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot free this cycle: skid (older) has priority over the input.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign opcode_o  = out_q.opcode;
  assign rd_o      = out_q.rd;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign funct3_o  = out_q.funct3;
  assign funct7_o  = out_q.funct7;
  assign fmt_o     = out_q.fmt;
  assign imm_o     = out_q.imm;
  assign illegal_o = out_q.illegal;
  assign pc_o      = out_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-decoded vectors, backpressure, flush and mid-stream reset.
module tb_decode_stage;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        ill;
    logic        ill_nom;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid, out_ready;
  logic [31:0] inst_i, pc_i;
  logic        in_ready, out_valid, illegal_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o, fmt_o;
  logic [31:0] imm_o, pc_o;

  logic        n_in_ready, n_out_valid, n_illegal;
  logic [6:0]  n_opcode, n_funct7;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  logic [2:0]  n_funct3, n_fmt;
  logic [31:0] n_imm, n_pc;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_out  = 0;
  exp_t expq[$];
  exp_t cur;
  exp_t mon_e;
  vec_t tab[14];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_WIDTH(32), .M_EXT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .pc_i(pc_i), .out_valid(out_valid), .out_ready(out_ready),
    .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .fmt_o(fmt_o), .imm_o(imm_o), .illegal_o(illegal_o), .pc_o(pc_o));

  decode_stage #(.XLEN(32), .PC_WIDTH(32), .M_EXT_EN(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(n_in_ready),
    .inst_i(inst_i), .pc_i(pc_i), .out_valid(n_out_valid), .out_ready(out_ready),
    .opcode_o(n_opcode), .rd_o(n_rd), .rs1_o(n_rs1), .rs2_o(n_rs2), .funct3_o(n_funct3),
    .funct7_o(n_funct7), .fmt_o(n_fmt), .imm_o(n_imm), .illegal_o(n_illegal), .pc_o(n_pc));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [6:0] op, input logic [2:0] fmt,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                              input logic ill, input logic ill_nom);
    vec_t v;
    v.inst = inst; v.opcode = op; v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.funct3 = f3; v.funct7 = f7; v.imm = imm; v.ill = ill; v.ill_nom = ill_nom;
    return v;
  endfunction

  // Expected queue follows the handshake as seen at the clock edge.
  always @(posedge clk) begin
    if (rst || flush_i) expq.delete();
    else if (in_valid && in_ready) begin
      expq.push_back(cur);
      n_acc++;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=pc %0h expected=no output", pc_o);
      end else begin
        mon_e = expq.pop_front();
        n_out++;
        chk("opcode", opcode_o, mon_e.v.opcode);
        chk("fmt", fmt_o, mon_e.v.fmt);
        chk("rd", rd_o, mon_e.v.rd);
        chk("rs1", rs1_o, mon_e.v.rs1);
        chk("rs2", rs2_o, mon_e.v.rs2);
        chk("funct3", funct3_o, mon_e.v.funct3);
        chk("funct7", funct7_o, mon_e.v.funct7);
        chk("imm", imm_o, mon_e.v.imm);
        chk("illegal", illegal_o, mon_e.v.ill);
        chk("pc", pc_o, mon_e.pc);
        chk("nom_valid", n_out_valid, 1'b1);
        chk("nom_fields", {n_opcode, n_fmt, n_rd, n_rs1, n_rs2, n_funct3, n_funct7, n_imm, n_pc},
            {mon_e.v.opcode, mon_e.v.fmt, mon_e.v.rd, mon_e.v.rs1, mon_e.v.rs2,
             mon_e.v.funct3, mon_e.v.funct7, mon_e.v.imm, mon_e.pc});
        chk("nom_illegal", n_illegal, mon_e.v.ill_nom);
      end
    end
  end

  task automatic send(input int idx, input logic [31:0] pc);
    int n = 0;
    bit acc = 1'b0;
    inst_i   = tab[idx].inst;
    pc_i     = pc;
    cur.v    = tab[idx];
    cur.pc   = pc;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_fmt"}, fmt_o, 3'd7);
    chk({tag, "_data"}, {opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_o, illegal_o, pc_o}, '0);
  endtask

  initial begin
    int acc0;
    tab[0]  = mk(32'h002081b3, 7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 1'b0);
    tab[1]  = mk(32'h05408113, 7'h13, 3'd1, 5'd2, 5'd1, 5'd0, 3'd0, 7'h02, 32'h54, 1'b0, 1'b0);
    tab[2]  = mk(32'h000230b7, 7'h37, 3'd4, 5'd1, 5'd0, 5'd0, 3'd3, 7'h00, 32'h00023000, 1'b0, 1'b0);
    tab[3]  = mk(32'hfe111ce3, 7'h63, 3'd3, 5'd0, 5'd2, 5'd1, 3'd1, 7'h7f, 32'hfffffff8, 1'b0, 1'b0);
    tab[4]  = mk(32'hff9ff26f, 7'h6f, 3'd5, 5'd4, 5'd0, 5'd0, 3'd7, 7'h7f, 32'hfffffff8, 1'b0, 1'b0);
    tab[5]  = mk(32'h022081b3, 7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'h0, 1'b0, 1'b1);
    tab[6]  = mk(32'hffffffff, 7'h7f, 3'd7, 5'd31, 5'd31, 5'd0, 3'd7, 7'h7f, 32'h0, 1'b1, 1'b1);
    tab[7]  = mk(32'h00112623, 7'h23, 3'd2, 5'd0, 5'd2, 5'd1, 3'd2, 7'h00, 32'hc, 1'b0, 1'b0);
    tab[8]  = mk(32'h40208033, 7'h33, 3'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0, 1'b0);
    tab[9]  = mk(32'h40209033, 7'h33, 3'd0, 5'd0, 5'd1, 5'd2, 3'd1, 7'h20, 32'h0, 1'b1, 1'b1);
    tab[10] = mk(32'h0020a063, 7'h63, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0, 1'b1, 1'b1);
    tab[11] = mk(32'h02109093, 7'h13, 3'd1, 5'd1, 5'd1, 5'd0, 3'd1, 7'h01, 32'h21, 1'b1, 1'b1);
    tab[12] = mk(32'h002081b0, 7'h30, 3'd7, 5'd3, 5'd1, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1, 1'b1);
    tab[13] = mk(32'hfff00093, 7'h13, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7f, 32'hffffffff, 1'b0, 1'b0);

    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst_i = '0; pc_i = '0; cur.v = tab[0]; cur.pc = '0;
    #3;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-rate stream; first result must be visible right after its accept edge.
    send(0, 32'h1000);
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_rd", rd_o, 5'd3);
    for (int i = 1; i < 14; i++) send(i, 32'h1000 + 32'(4 * i));
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two entries fill, third waits until the stall lifts.
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) send(i, 32'h2000 + 32'(4 * i));
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_accepted", n_acc - acc0, 2);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_hold_pc", pc_o, 32'h2000);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Flush with both entries occupied and a new instruction offered.
    out_ready = 1'b0;
    send(5, 32'h3000);
    send(6, 32'h3004);
    chk("flush_pre_in_ready", in_ready, 1'b0);
    flush_i = 1'b1; in_valid = 1'b1; inst_i = tab[7].inst; pc_i = 32'h3008;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_nom_in_ready", n_in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream with held entries.
    out_ready = 1'b0;
    send(3, 32'h4000);
    send(4, 32'h4004);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(13, 32'h5000);
    repeat (4) @(posedge clk);
    #1;

    chk("queue_empty", expq.size(), 0);
    chk("delivered", n_out, 19);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
